// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared FSM encodings and width helper for the register bank arbiter
package reg_bank_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Minimum index width for n items, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// rtl/reg_bank_arbiter_rr_pick.sv - combinational round-robin winner selection
import reg_bank_pkg::*;

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  // Scan ptr, ptr+1, ... wrapping; the first set request wins.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        win[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin shared register bank, one transaction per four cycles
import reg_bank_pkg::*;

module reg_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rd_vld,
  output logic                      busy
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int DEPTH = 1 << ADDR_W;

  logic [1:0]          state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    idx_l;
  logic [NUM_REQ-1:0]  win_l;
  logic                we_l;
  logic [ADDR_W-1:0]   addr_l;
  logic [DATA_W-1:0]   wdata_l;
  logic [DATA_W-1:0]   bank [DEPTH];

  logic [NUM_REQ-1:0]  pick_win;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign busy = (state != IDLE);

  // Transaction sequencer: latch the winner in IDLE, then grant, execute, acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      idx_l   <= '0;
      win_l   <= '0;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      gnt     <= '0;
      ack     <= '0;
      rd_vld  <= 1'b0;
      rdata   <= '0;
    end else begin
      gnt    <= '0;
      ack    <= '0;
      rd_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            idx_l   <= pick_idx;
            win_l   <= pick_win;
            we_l    <= we[pick_idx];
            addr_l  <= addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_l <= wdata[int'(pick_idx)*DATA_W +: DATA_W];
            gnt     <= pick_win;
            state   <= GRANT;
          end
        end
        GRANT: state <= EXEC;
        EXEC: begin
          // rdata is only touched by reads so it keeps the last read value across writes.
          if (!we_l) rdata <= bank[addr_l];
          ack    <= win_l;
          rd_vld <= ~we_l;
          state  <= DONE;
        end
        DONE: begin
          ptr   <= (idx_l == IDX_W'(NUM_REQ-1)) ? '0 : idx_l + IDX_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank storage: cleared by reset so an aborted write never survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (state == EXEC && we_l) begin
      bank[addr_l] <= wdata_l;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - directed table-driven bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, we, gnt, ack;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic [15:0] rdata;
  logic        rd_vld, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [3:0]  exp_ack;
    logic        exp_rv;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  reg_bank_arbiter #(.NUM_REQ(4), .DATA_W(16), .ADDR_W(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .ack    (ack),
    .rdata  (rdata),
    .rd_vld (rd_vld),
    .busy   (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Grant and ack must be exclusive and each at most one-hot.
  always @(negedge clk) begin
    if (!reset)
      check("gnt_ack_excl", {29'd0, (gnt != 4'd0) && (ack != 4'd0), $onehot0(gnt), $onehot0(ack)}, 32'd3);
  end

  task automatic drive(input logic [3:0] r, input logic w, input logic [1:0] a, input logic [15:0] d);
    req   = r;
    we    = {4{w}};
    addr  = {4{a}};
    wdata = {4{d}};
  endtask

  task automatic wait_ack(output logic [3:0] g_seen, output logic b_seen, output int cyc);
    cyc    = 0;
    g_seen = '0;
    b_seen = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        g_seen = gnt;
        b_seen = busy;
      end
    end while (ack == 4'd0 && cyc < 10);
  endtask

  task automatic do_txn(input string name, input logic [3:0] r, input logic w, input logic [1:0] a,
                        input logic [15:0] d, input logic [3:0] e_ack, input logic e_rv,
                        input logic [15:0] e_rd);
    logic [3:0] g;
    logic       b;
    int         cyc;
    drive(r, w, a, d);
    wait_ack(g, b, cyc);
    check({name, "_gnt"}, {28'd0, g}, {28'd0, e_ack});
    check({name, "_busy"}, {31'd0, b}, 32'd1);
    check({name, "_lat"}, cyc, 32'd3);
    check({name, "_ack"}, {28'd0, ack}, {28'd0, e_ack});
    check({name, "_rdvld"}, {31'd0, rd_vld}, {31'd0, e_rv});
    check({name, "_rdata"}, {16'd0, rdata}, {16'd0, e_rd});
    req = 4'd0;
    @(negedge clk);
    check({name, "_idle"}, {30'd0, busy, ack != 4'd0}, 32'd0);
  endtask

  initial begin
    logic [3:0] g;
    logic       b;
    int         cyc;
    logic [3:0] order [5];

    vecs[0] = '{4'b0001, 1'b1, 2'd2, 16'h2933, 4'b0001, 1'b0, 16'h0000};
    vecs[1] = '{4'b0001, 1'b0, 2'd2, 16'h0000, 4'b0001, 1'b1, 16'h2933};
    vecs[2] = '{4'b0100, 1'b1, 2'd3, 16'h0A5C, 4'b0100, 1'b0, 16'h2933};
    vecs[3] = '{4'b1001, 1'b0, 2'd3, 16'h0000, 4'b1000, 1'b1, 16'h0A5C};
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    reset = 1'b1;
    drive(4'd0, 1'b0, 2'd0, 16'd0);
    repeat (2) @(negedge clk);
    check("reset_outs", {gnt, ack, rdata, rd_vld, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      do_txn($sformatf("v%0d", i), vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_ack, vecs[i].exp_rv, vecs[i].exp_rdata);

    // All four requesters held high, reads of addr 2: round-robin with wrap.
    drive(4'b1111, 1'b0, 2'd2, 16'd0);
    for (int k = 0; k < 5; k++) begin
      wait_ack(g, b, cyc);
      check($sformatf("rr%0d_ack", k), {28'd0, ack}, {28'd0, order[k]});
      check($sformatf("rr%0d_lat", k), cyc, (k == 0) ? 32'd3 : 32'd4);
      check($sformatf("rr%0d_rdata", k), {15'd0, rd_vld, rdata}, {15'd0, 1'b1, 16'h2933});
    end
    req = 4'd0;
    @(negedge clk);

    // Late change of write data after the request was latched is ignored.
    drive(4'b0010, 1'b1, 2'd1, 16'h1133);
    @(negedge clk);
    check("late_gnt", {28'd0, gnt}, 32'h2);
    wdata = {4{16'hFFFF}};
    addr  = 8'd0;
    wait_ack(g, b, cyc);
    check("late_ack", {28'd0, ack}, 32'h2);
    check("late_lat", cyc, 32'd2);
    req = 4'd0;
    @(negedge clk);
    do_txn("late_rd", 4'b0010, 1'b0, 2'd1, 16'd0, 4'b0010, 1'b1, 16'h1133);
    do_txn("late_rd0", 4'b0100, 1'b0, 2'd0, 16'd0, 4'b0100, 1'b1, 16'h0000);

    // Reset during EXEC of a write to addr 3.
    drive(4'b0001, 1'b1, 2'd3, 16'h88F3);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_outs", {gnt, ack, rdata, rd_vld, busy}, 32'd0);
    req = 4'd0;
    @(negedge clk);
    check("rst_noack", {28'd0, ack}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_noack2", {27'd0, ack, busy}, 32'd0);
    do_txn("rst_rd3", 4'b0001, 1'b0, 2'd3, 16'd0, 4'b0001, 1'b1, 16'h0000);
    do_txn("rst_rd1", 4'b0001, 1'b0, 2'd1, 16'd0, 4'b0001, 1'b1, 16'h0000);

    // rdata holds the last read value across a later write.
    do_txn("hold_wr", 4'b0001, 1'b1, 2'd0, 16'h5A5A, 4'b0001, 1'b0, 16'h0000);
    do_txn("hold_rd", 4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 1'b1, 16'h5A5A);
    do_txn("hold_wr2", 4'b0010, 1'b1, 2'd0, 16'h1234, 4'b0010, 1'b0, 16'h5A5A);
    check("hold_final", {16'd0, rdata}, 32'h5A5A);
    do_txn("hold_rd2", 4'b0100, 1'b0, 2'd0, 16'd0, 4'b0100, 1'b1, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
